// File: rtl/top_level_mult.sv
// top_level_mult: multiplies NUM_PAIRS pairs of signed 16-bit operands held in
// a local byte-wide data memory and writes the 32-bit products back, big-endian.
// Optional build macro MULT_SHIFT_ADD_EN selects an iterative 16-cycle
// shift-add multiplier in place of the single-cycle multiply.

// Byte-wide data memory: combinational read, synchronous write, never reset.
module data_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] core [0:DEPTH-1];

  assign rdata = core[addr];

  // single write port; contents survive reset on purpose
  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end
endmodule

module top_level_mult #(
  parameter int NUM_PAIRS = 16,
  parameter int SRC_BASE  = 0,
  parameter int DST_BASE  = 64,
  parameter int MEM_DEPTH = 256
) (
  input  logic clk,
  input  logic reset,
  output logic done
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;

  typedef enum logic [1:0] {LOAD, MUL, STORE, DONE} state_t;

  state_t               state, nstate;
  logic [PW-1:0]        pair;
  logic [1:0]           bcnt;
  logic signed [15:0]   opa;    // operand(2k), multiplier
  logic signed [15:0]   opb;    // operand(2k+1), multiplicand
  logic signed [31:0]   prod;
  logic signed [31:0]   mcand;

  logic                 we;
  logic [AW-1:0]        addr;
  logic [7:0]           wdata;
  logic [7:0]           rdata;
  logic [AW-1:0]        src_addr;
  logic [AW-1:0]        dst_addr;
  logic                 last_pair;

  // pair k occupies 4 source bytes and 4 destination bytes, so {pair,bcnt} is the offset
  assign src_addr  = AW'(SRC_BASE) + AW'({pair, bcnt});
  assign dst_addr  = AW'(DST_BASE) + AW'({pair, bcnt});
  assign last_pair = (pair == PW'(NUM_PAIRS - 1));
  assign mcand     = 32'(opb);
  // bcnt 0 writes the MSB: bit offset = 8*(3-bcnt) = {~bcnt, 3'b000}
  assign wdata     = prod[{~bcnt, 3'b000} +: 8];

`ifdef MULT_SHIFT_ADD_EN
  logic [3:0]         step;
  logic signed [31:0] pp;

  // partial product for the current multiplier bit; bit 15 carries negative weight
  always_comb begin
    pp = '0;
    if (opa[step]) pp = (step == 4'd15) ? -(mcand <<< step) : (mcand <<< step);
  end
`endif

  data_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) dm1 (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  // next-state, memory address and write enable
  always_comb begin
    nstate = state;
    we     = 1'b0;
    addr   = src_addr;
    case (state)
      LOAD:  if (bcnt == 2'd3) nstate = MUL;
      MUL: begin
`ifdef MULT_SHIFT_ADD_EN
        if (step == 4'd15) nstate = STORE;
`else
        nstate = STORE;
`endif
      end
      STORE: begin
        addr = dst_addr;
        we   = 1'b1;
        if (bcnt == 2'd3) nstate = last_pair ? DONE : LOAD;
      end
      DONE:  nstate = DONE;
      default: nstate = LOAD;
    endcase
  end

  // state, counters, operand/product datapath and registered done
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
      pair  <= '0;
      bcnt  <= '0;
      opa   <= '0;
      opb   <= '0;
      prod  <= '0;
      done  <= 1'b0;
`ifdef MULT_SHIFT_ADD_EN
      step  <= '0;
`endif
    end else begin
      state <= nstate;
      done  <= (nstate == DONE);
      case (state)
        LOAD: begin
          case (bcnt)
            2'd0: opa[15:8] <= rdata;
            2'd1: opa[7:0]  <= rdata;
            2'd2: opb[15:8] <= rdata;
            default: opb[7:0] <= rdata;
          endcase
          bcnt <= bcnt + 2'd1;
`ifdef MULT_SHIFT_ADD_EN
          // accumulator starts clean for every pair
          if (bcnt == 2'd3) begin
            prod <= '0;
            step <= '0;
          end
`endif
        end
        MUL: begin
`ifdef MULT_SHIFT_ADD_EN
          prod <= prod + pp;
          step <= step + 4'd1;
`else
          prod <= mcand * 32'(opa);
`endif
        end
        STORE: begin
          bcnt <= bcnt + 2'd1;
          if (bcnt == 2'd3 && !last_pair) pair <= pair + PW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_top_level_mult.sv
// Bench for top_level_mult: preloads operands through the memory hierarchy,
// checks done timing and every stored product against a plain-arithmetic model.
module tb_top_level_mult;
`ifdef MULT_SHIFT_ADD_EN
  localparam int LAT = 384;
`else
  localparam int LAT = 144;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic done;
  int   nerr = 0;
  int   nchk = 0;
  logic [7:0] src [0:63];

  always #5 clk = ~clk;

  top_level_mult dut (.clk(clk), .reset(reset), .done(done));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference: operand(2k+1) * operand(2k), each a big-endian signed 16-bit value
  function automatic logic [31:0] ref_prod(input int k);
    int a, b;
    a = int'($signed({src[4*k], src[4*k+1]}));
    b = int'($signed({src[4*k+2], src[4*k+3]}));
    return 32'(a * b);
  endfunction

  task automatic set_pair(input int k, input logic [15:0] a, input logic [15:0] b);
    src[4*k]   = a[15:8];
    src[4*k+1] = a[7:0];
    src[4*k+2] = b[15:8];
    src[4*k+3] = b[7:0];
  endtask

  // copy model sources into the DUT and poison the destination region
  task automatic push_mem();
    for (int i = 0; i < 64; i++) dut.dm1.core[i] = src[i];
    for (int i = 64; i < 128; i++) dut.dm1.core[i] = 8'hA5;
  endtask

  task automatic rand_src();
    for (int i = 0; i < 64; i++) src[i] = 8'($urandom);
  endtask

  function automatic logic [31:0] got_prod(input int k);
    return {dut.dm1.core[64+4*k], dut.dm1.core[65+4*k],
            dut.dm1.core[66+4*k], dut.dm1.core[67+4*k]};
  endfunction

  // release reset, time done, then check products and untouched sources
  task automatic run_check(input string tag);
    int first_hi;
    int diffs;
    first_hi = 0;
    @(negedge clk) reset = 1'b1;
    for (int e = 1; e <= LAT + 20; e++) begin
      @(posedge clk);
      #1;
      if (done && first_hi == 0) first_hi = e;
    end
    chk({tag, "_lat"}, 32'(first_hi), 32'(LAT));
    for (int k = 0; k < 16; k++)
      chk($sformatf("%s_p%0d", tag, k), got_prod(k), ref_prod(k));
    diffs = 0;
    for (int i = 0; i < 64; i++) if (dut.dm1.core[i] !== src[i]) diffs++;
    chk({tag, "_src"}, 32'(diffs), 32'd0);
  endtask

  initial begin
    int lows;
    logic [31:0] old_p0;

    // directed pairs from the basic, sign and extreme cases; rest random
    rand_src();
    set_pair(0, 16'h0005, 16'h0003);
    set_pair(1, 16'h0001, 16'hFFFF);
    set_pair(2, 16'h8000, 16'h8000);
    set_pair(3, 16'h8000, 16'h7FFF);
    set_pair(4, 16'h0000, 16'h1234);
    push_mem();
    repeat (3) @(posedge clk);
    #1 chk("rst_done", {31'd0, done}, 32'd0);

    run_check("dir");
    chk("basic", got_prod(0), 32'h0000000F);
    chk("sign", got_prod(1), 32'hFFFFFFFF);
    chk("minmin", got_prod(2), 32'h40000000);
    chk("minmax", got_prod(3), 32'hC0008000);
    chk("zero", got_prod(4), 32'h00000000);

    // done must stay high with no further writes
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (!done) lows++;
    end
    chk("hold", 32'(lows), 32'd0);
    chk("hold_p0", got_prod(0), 32'h0000000F);

    @(negedge clk) reset = 1'b0;
    #1 chk("rst_async", {31'd0, done}, 32'd0);

    for (int r = 0; r < 2; r++) begin
      rand_src();
      push_mem();
      @(negedge clk);
      run_check($sformatf("rnd%0d", r));
      @(negedge clk) reset = 1'b0;
    end

    // abort in the middle of a run, then restart with fresh operands
    rand_src();
    push_mem();
    @(negedge clk) reset = 1'b1;
    repeat (50) @(posedge clk);
    #2 reset = 1'b0;
    #1 chk("abort_done", {31'd0, done}, 32'd0);
    old_p0 = ref_prod(0);
    chk("abort_keep", got_prod(0), old_p0);
    @(negedge clk);
    rand_src();
    for (int i = 0; i < 64; i++) dut.dm1.core[i] = src[i];
    @(negedge clk);
    run_check("restart");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
